// File: rtl/pulse_extender_pkg.sv
// Shared types and default sizing for the multi-channel pulse extender.
package pulse_extender_pkg;

    localparam int PE_STATE_W          = 2;
    localparam int PE_DEFAULT_CHANNELS = 8;
    localparam int PE_DEFAULT_CNT_W    = 8;

    typedef enum logic [PE_STATE_W-1:0] {
        PE_IDLE    = 2'd0,
        PE_ACTIVE  = 2'd1,
        PE_HOLDOFF = 2'd2
    } pe_state_t;

endpackage

// File: rtl/pulse_extender_chan.sv
// One channel: edge detect, IDLE/ACTIVE/HOLDOFF FSM, saturating counter and sticky miss flag.
module pulse_extender_chan
    import pulse_extender_pkg::*;
#(
    parameter int CNT_W = PE_DEFAULT_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CNT_W-1:0] cfg_len_i,
    input  logic [CNT_W-1:0] cfg_holdoff_i,
    input  logic             cfg_retrig_i,
    input  logic             clr_missed_i,
    input  logic             d_i,
    output logic             q_o,
    output logic             busy_o,
    output logic             missed_o
);

    pe_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_eff, cnt_inc;
    logic             d_prev_q;
    logic             rise;
    logic             miss_set;
    logic             q_q, q_d;
    logic             busy_q, busy_d;
    logic             missed_q, missed_d;

    // A zero length still yields a single-cycle pulse; the counter sticks at all-ones so long lengths never wrap.
    always_comb begin
        rise    = d_i & ~d_prev_q;
        len_eff = (cfg_len_i == '0) ? CNT_W'(1) : cfg_len_i;
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= PE_IDLE;
            cnt_q    <= '0;
            d_prev_q <= 1'b0;
            q_q      <= 1'b0;
            busy_q   <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            d_prev_q <= d_i;
            q_q      <= q_d;
            busy_q   <= busy_d;
            missed_q <= missed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        miss_set = 1'b0;
        case (state_q)
            PE_IDLE: begin
                if (rise) begin
                    state_d = PE_ACTIVE;
                    cnt_d   = CNT_W'(1);
                end
            end
            PE_ACTIVE: begin
                cnt_d = cnt_inc;
                if (rise) begin
                    if (cfg_retrig_i) begin
                        cnt_d = CNT_W'(1);
                    end else begin
                        miss_set = 1'b1;
                    end
                // Exit needs d low, so a live config change can never cut a pulse shorter than d itself.
                end else if (!d_i && (cnt_q >= len_eff)) begin
                    if (cfg_holdoff_i == '0) begin
                        state_d = PE_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = PE_HOLDOFF;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            PE_HOLDOFF: begin
                cnt_d = cnt_inc;
                if (rise) begin
                    miss_set = 1'b1;
                end
                if (cnt_q >= cfg_holdoff_i) begin
                    state_d = PE_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = PE_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A new miss outranks a clear arriving in the same cycle.
    always_comb begin
        q_d      = (state_d == PE_ACTIVE);
        busy_d   = (state_d != PE_IDLE);
        missed_d = miss_set | (missed_q & ~clr_missed_i);
    end

    assign q_o      = q_q;
    assign busy_o   = busy_q;
    assign missed_o = missed_q;

endmodule

// File: rtl/pulse_extender_mc.sv
// Multi-channel pulse extender: fans shared config out to independent per-channel instances.
module pulse_extender_mc
    import pulse_extender_pkg::*;
#(
    parameter int CHANNELS = PE_DEFAULT_CHANNELS,
    parameter int CNT_W    = PE_DEFAULT_CNT_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CNT_W-1:0]    cfg_len_i,
    input  logic [CNT_W-1:0]    cfg_holdoff_i,
    input  logic [CHANNELS-1:0] cfg_retrig_i,
    input  logic [CHANNELS-1:0] clr_missed_i,
    input  logic [CHANNELS-1:0] d_i,
    output logic [CHANNELS-1:0] q_o,
    output logic [CHANNELS-1:0] busy_o,
    output logic [CHANNELS-1:0] missed_o
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        pulse_extender_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .cfg_len_i    (cfg_len_i),
            .cfg_holdoff_i(cfg_holdoff_i),
            .cfg_retrig_i (cfg_retrig_i[i]),
            .clr_missed_i (clr_missed_i[i]),
            .d_i          (d_i[i]),
            .q_o          (q_o[i]),
            .busy_o       (busy_o[i]),
            .missed_o     (missed_o[i])
        );
    end

endmodule
